// File: rtl/vga_pkg.sv
// Purpose : shared text-mode geometry defaults and sequencer state encoding.
// Latency : n/a (package only).
// Backpressure: n/a (package only).
//
// Contents:
//   *_DEF       default geometry for 640x400 text mode (80x25 cells of 8x16 pixels)
//   seq_state_t frame sequencer states
//   cnt_w()     width of an index counter for n positions (at least 1 bit)
package vga_pkg;

  localparam int ADDR_W_DEF  = 11;
  localparam int H_CHARS_DEF = 80;
  localparam int V_ROWS_DEF  = 25;
  localparam int CHAR_W_DEF  = 8;
  localparam int CHAR_H_DEF  = 16;

  typedef enum logic [1:0] {
    WAIT_SOF = 2'd0,
    ACTIVE   = 2'd1,
    DONE     = 2'd2
  } seq_state_t;

  // A 1-position counter still needs a 1-bit port to stay a legal vector.
  function automatic int cnt_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/vga_vram_pos.sv
// Purpose : loadable VRAM position counter; holds the address of the cell under the beam.
// Latency : load or increment visible one clock after the strobe.
// Backpressure: none; load has priority over enable, otherwise holds.
//
// Ports:
//   i_clk      clock
//   i_ld_h     load i_ld_data (also used as the reset path by the parent)
//   i_en_h     advance position by one, modulo 2**ADDR_W
//   i_ld_data  value to load
//   o_pos      registered position
module vga_vram_pos
  import vga_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              i_clk,
  input  logic              i_ld_h,
  input  logic              i_en_h,
  input  logic [ADDR_W-1:0] i_ld_data,
  output logic [ADDR_W-1:0] o_pos
);

  logic [ADDR_W-1:0] r_pos;

  // No reset input: the parent forces a load of zero while its reset is high.
  always_ff @(posedge i_clk) begin
    if (i_ld_h) begin
      r_pos <= i_ld_data;
    end else if (i_en_h) begin
      r_pos <= r_pos + ADDR_W'(1);
    end
  end

  assign o_pos = r_pos;

endmodule

// File: rtl/vga_vram_addr_seq.sv
// Purpose : sequences the text-mode VRAM cell address from VGA timing strobes, with per-frame scroll origin.
// Latency : i_sof / i_eol / last pixel of a cell -> new o_vram_addr one clock later; all outputs registered.
// Backpressure: none; strobes are consumed every cycle, i_pix_en qualifies pixel advance only.
//
// Ports:
//   i_clk, i_rst          clock, synchronous active-high reset
//   i_pix_en              pixel clock enable
//   i_sof                 start-of-frame pulse (restarts the frame from any state)
//   i_hactive             horizontal active region
//   i_eol                 end-of-active-line pulse
//   i_start_addr          scroll origin, sampled only on i_sof
//   o_vram_addr           address of the current character cell
//   o_addr_valid          high while the frame is in its active text area
//   o_char_x              pixel index within the cell
//   o_font_row            scanline within the character row
//   o_text_row            text row index
module vga_vram_addr_seq
  import vga_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int H_CHARS = H_CHARS_DEF,
  parameter int V_ROWS  = V_ROWS_DEF,
  parameter int CHAR_W  = CHAR_W_DEF,
  parameter int CHAR_H  = CHAR_H_DEF
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_pix_en,
  input  logic                       i_sof,
  input  logic                       i_hactive,
  input  logic                       i_eol,
  input  logic [ADDR_W-1:0]          i_start_addr,
  output logic [ADDR_W-1:0]          o_vram_addr,
  output logic                       o_addr_valid,
  output logic [cnt_w(CHAR_W)-1:0]   o_char_x,
  output logic [cnt_w(CHAR_H)-1:0]   o_font_row,
  output logic [cnt_w(V_ROWS)-1:0]   o_text_row
);

  localparam int CX_W = cnt_w(CHAR_W);
  localparam int FR_W = cnt_w(CHAR_H);
  localparam int TR_W = cnt_w(V_ROWS);

  localparam logic [CX_W-1:0]   CX_LAST    = CX_W'(CHAR_W - 1);
  localparam logic [FR_W-1:0]   FR_LAST    = FR_W'(CHAR_H - 1);
  localparam logic [TR_W-1:0]   TR_LAST    = TR_W'(V_ROWS - 1);
  localparam logic [ADDR_W-1:0] ROW_STRIDE = ADDR_W'(H_CHARS);

  seq_state_t        r_state;
  seq_state_t        w_state_nxt;
  logic [ADDR_W-1:0] r_row_base;
  logic [CX_W-1:0]   r_char_x;
  logic [FR_W-1:0]   r_font_row;
  logic [TR_W-1:0]   r_text_row;

  logic              w_in_active;
  logic              w_eol_act;
  logic              w_pix_act;
  logic              w_cell_end;
  logic              w_row_done;
  logic [ADDR_W-1:0] w_next_base;
  logic              w_ld;
  logic [ADDR_W-1:0] w_ld_data;

  // ---------------------------------------------------------------------------
  // Strobe decode. i_sof masks everything else; i_eol masks pixel advance, so
  // a pixel coinciding with eol never bumps the counter past the reload.
  // ---------------------------------------------------------------------------
  assign w_in_active = (r_state == ACTIVE);
  assign w_eol_act   = w_in_active & i_eol & ~i_sof;
  assign w_pix_act   = w_in_active & ~i_sof & ~i_eol & i_pix_en & i_hactive;
  assign w_cell_end  = w_pix_act & (r_char_x == CX_LAST);
  assign w_row_done  = (r_font_row == FR_LAST);
  assign w_next_base = r_row_base + ROW_STRIDE;

  assign w_ld = i_rst | i_sof | w_eol_act;

  // On the last scanline of a text row the counter takes the advanced base
  // directly, in the same cycle that r_row_base itself is updated.
  always_comb begin
    w_ld_data = r_row_base;
    if (i_rst) begin
      w_ld_data = '0;
    end else if (i_sof) begin
      w_ld_data = i_start_addr;
    end else if (w_row_done) begin
      w_ld_data = w_next_base;
    end
  end

  vga_vram_pos #(
    .ADDR_W (ADDR_W)
  ) u_pos (
    .i_clk     (i_clk),
    .i_ld_h    (w_ld),
    .i_en_h    (w_cell_end),
    .i_ld_data (w_ld_data),
    .o_pos     (o_vram_addr)
  );

  // ---------------------------------------------------------------------------
  // Frame FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    if (i_sof) begin
      w_state_nxt = ACTIVE;
    end else if (w_eol_act && w_row_done && (r_text_row == TR_LAST)) begin
      w_state_nxt = DONE;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= WAIT_SOF;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Cell / scanline / row counters and row base
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_row_base <= '0;
      r_char_x   <= '0;
      r_font_row <= '0;
      r_text_row <= '0;
    end else if (i_sof) begin
      r_row_base <= i_start_addr;
      r_char_x   <= '0;
      r_font_row <= '0;
      r_text_row <= '0;
    end else if (w_eol_act) begin
      r_char_x <= '0;
      if (w_row_done) begin
        r_font_row <= '0;
        r_text_row <= r_text_row + TR_W'(1);
        r_row_base <= w_next_base;
      end else begin
        r_font_row <= r_font_row + FR_W'(1);
      end
    end else if (w_pix_act) begin
      if (r_char_x == CX_LAST) begin
        r_char_x <= '0;
      end else begin
        r_char_x <= r_char_x + CX_W'(1);
      end
    end
  end

  assign o_addr_valid = (r_state == ACTIVE);
  assign o_char_x     = r_char_x;
  assign o_font_row   = r_font_row;
  assign o_text_row   = r_text_row;

endmodule
